vif_stream_fifo: RTL and testbench



---
 rtl/vif_stream_fifo.sv | 96 +++++++++
 tb/tb_vif_stream_fifo.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vif_stream_fifo.sv
// Valid/ready buffering FIFO behind the my_if producer: first-word fall-through, occupancy status, sync flush.
// Optional high-water-mark output is enabled by defining VIF_FIFO_HWM_EN.
module vif_stream_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
`ifdef VIF_FIFO_HWM_EN
   ,
   output logic [CNT_W-1:0]  hwm
`endif
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wp;
   logic [PTR_W-1:0]  rp;
   logic              push;
   logic              pop;
   logic [CNT_W-1:0]  count_nxt;

   // Handshake status depends only on registered count, never on in_valid/out_ready.
   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign out_data  = mem[rp];

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   always_comb begin
      count_nxt = count;
      if (flush) begin
         count_nxt = '0;
      end else if (push && !pop) begin
         count_nxt = count + CNT_W'(1);
      end else if (pop && !push) begin
         count_nxt = count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         count <= count_nxt;
         if (flush) begin
            wp <= '0;
            rp <= '0;
         end else begin
            if (push) wp <= wp + PTR_W'(1);
            if (pop)  rp <= rp + PTR_W'(1);
         end
      end
   end

   // Storage is cleared on reset so out_data reads 0 while rst_n is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push && !flush) begin
         mem[wp] <= in_data;
      end
   end

`ifdef VIF_FIFO_HWM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hwm <= '0;
      end else if (flush) begin
         hwm <= '0;
      end else if (count_nxt > hwm) begin
         hwm <= count_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_vif_stream_fifo.sv
// Self-checking bench for vif_stream_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized traffic phase.
module tb_vif_stream_fifo;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   logic              clk;
   logic              rst_n;
   logic              flush;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              empty;
`ifdef VIF_FIFO_HWM_EN
   logic [CNT_W-1:0]  hwm;
`endif

   vif_stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count),
      .full      (full),
      .empty     (empty)
`ifdef VIF_FIFO_HWM_EN
      ,
      .hwm       (hwm)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: a plain queue of stored words plus a running maximum of its size.
   logic [DATA_W-1:0] q[$];
   int                m_hwm = 0;
   bit                started = 1'b0;

   always @(negedge rst_n) begin
      q.delete();
      m_hwm = 0;
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         q.delete();
         m_hwm = 0;
      end else if (flush) begin
         q.delete();
         m_hwm = 0;
      end else begin
         bit do_push;
         bit do_pop;
         do_push = in_valid && (q.size() < DEPTH);
         do_pop  = out_ready && (q.size() > 0);
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(in_data);
         if (q.size() > m_hwm) m_hwm = q.size();
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("model_count",     32'(count),     32'(q.size()));
         check("model_full",      32'(full),      32'(q.size() == DEPTH));
         check("model_empty",     32'(empty),     32'(q.size() == 0));
         check("model_in_ready",  32'(in_ready),  32'(q.size() < DEPTH));
         check("model_out_valid", 32'(out_valid), 32'(q.size() > 0));
         if (!rst_n)
            check("model_out_data_rst", 32'(out_data), 32'h0);
         else if (q.size() > 0)
            check("model_out_data", 32'(out_data), 32'(q[0]));
`ifdef VIF_FIFO_HWM_EN
         check("model_hwm", 32'(hwm), 32'(m_hwm));
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [DATA_W-1:0] d);
      in_data  = d;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      logic [DATA_W-1:0] drain_exp [5];
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #3;
      check("rst_in_ready",  32'(in_ready),  32'h1);
      check("rst_empty",     32'(empty),     32'h1);
      check("rst_full",      32'(full),      32'h0);
      check("rst_count",     32'(count),     32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_data",  32'(out_data),  32'h0);
      started = 1'b1;
      step();
      step();
      rst_n = 1'b1;

      // Single word through, then popped.
      push_word(8'hA5);
      check("single_valid", 32'(out_valid), 32'h1);
      check("single_data",  32'(out_data),  32'hA5);
      check("single_count", 32'(count),     32'h1);
      check("single_empty", 32'(empty),     32'h0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("single_drained_empty", 32'(empty), 32'h1);
      check("single_drained_count", 32'(count), 32'h0);

      // Fill to full, hold a blocked word, pop once, then drain.
      for (int i = 1; i <= 4; i++) push_word(DATA_W'(i));
      check("fill_full",     32'(full),     32'h1);
      check("fill_in_ready", 32'(in_ready), 32'h0);
      check("fill_count",    32'(count),    32'h4);
      in_data  = 8'h05;
      in_valid = 1'b1;
      step();
      check("blocked_count", 32'(count), 32'h4);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("after_pop_in_ready", 32'(in_ready), 32'h1);
      check("after_pop_count",    32'(count),    32'h3);
      step();
      in_valid = 1'b0;
      check("refill_count", 32'(count), 32'h4);
`ifdef VIF_FIFO_HWM_EN
      check("hwm_after_fill", 32'(hwm), 32'h4);
`endif
      drain_exp[0] = 8'h02; drain_exp[1] = 8'h03; drain_exp[2] = 8'h04; drain_exp[3] = 8'h05;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_order", 32'(out_data), 32'(drain_exp[i]));
         step();
      end
      out_ready = 1'b0;
      check("drain_empty", 32'(empty), 32'h1);

      // Simultaneous push and pop at count=2, then continuous streaming across wraps.
      push_word(8'h20);
      push_word(8'h21);
      in_data   = 8'h10;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      check("pushpop_count", 32'(count),    32'h2);
      check("pushpop_head",  32'(out_data), 32'h21);
      for (int i = 0; i < 3 * DEPTH; i++) begin
         in_data = DATA_W'(8'h40 + i);
         step();
         check("stream_count", 32'(count), 32'h2);
      end
      in_valid = 1'b0;
      step();
      step();
      out_ready = 1'b0;
      check("stream_drained", 32'(empty), 32'h1);

      // Backpressure stability.
      push_word(8'h33);
      push_word(8'h44);
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_data",  32'(out_data), 32'h33);
         check("bp_count", 32'(count),    32'h2);
      end

      // Flush at count=3 with concurrent push and pop.
      push_word(8'h55);
      check("preflush_count", 32'(count), 32'h3);
      in_data   = 8'h66;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      flush     = 1'b1;
      step();
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("flush_count", 32'(count), 32'h0);
      check("flush_empty", 32'(empty), 32'h1);
`ifdef VIF_FIFO_HWM_EN
      check("flush_hwm", 32'(hwm), 32'h0);
`endif
      step();
      check("flush_push_dropped", 32'(empty), 32'h1);

      // Asynchronous reset between edges with count=3.
      push_word(8'h71);
      push_word(8'h72);
      push_word(8'h73);
      check("prereset_count", 32'(count), 32'h3);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_out_valid", 32'(out_valid), 32'h0);
      check("async_count",     32'(count),     32'h0);
      check("async_in_ready",  32'(in_ready),  32'h1);
      check("async_out_data",  32'(out_data),  32'h0);
      step();
      rst_n = 1'b1;
      step();

      // Randomized traffic with occasional flush; the model checks every cycle.
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 99) < 60);
         out_ready = ($urandom_range(0, 99) < 50);
         in_data   = DATA_W'($urandom);
         flush     = ($urandom_range(0, 49) == 0);
         step();
      end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) step();
      check("final_empty", 32'(empty), 32'h1);

      started = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
